// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge control stage.
// APB_BRIDGE_ERR_EN adds the two-cycle ERROR response states for unmapped accesses.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_RENABLE = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WRITE   = 3'd4,
    ST_WENABLE = 3'd5
`ifdef APB_BRIDGE_ERR_EN
    ,
    ST_ERR1    = 3'd6,
    ST_ERR2    = 3'd7
`endif
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] P0_BASE  = 32'h8000_0000;
  localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] P1_BASE  = 32'h8400_0000;
  localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] P2_BASE  = 32'h8800_0000;
  localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] PSEL_NONE = 3'b000;
  localparam logic [2:0] PSEL_P0   = 3'b001;
  localparam logic [2:0] PSEL_P1   = 3'b010;
  localparam logic [2:0] PSEL_P2   = 3'b100;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address map: HADDR -> one-hot peripheral select plus mapped flag.
module apb_addr_decode
  import apb_bridge_pkg::*;
(
  input  logic [31:0] haddr_i,
  output logic        mapped_o,
  output logic [2:0]  psel_o
);

  always_comb begin
    psel_o = PSEL_NONE;
    if (in_range(haddr_i, P0_BASE, P0_LIMIT))      psel_o = PSEL_P0;
    else if (in_range(haddr_i, P1_BASE, P1_LIMIT)) psel_o = PSEL_P1;
    else if (in_range(haddr_i, P2_BASE, P2_LIMIT)) psel_o = PSEL_P2;
    mapped_o = |psel_o;
  end

endmodule

// File: rtl/apb_controller.sv
// AHB-Lite to APB control stage: one transfer in flight, Moore-registered APB outputs.
// Optional APB_BRIDGE_ERR_EN: unmapped active transfers get a two-cycle ERROR response.
module apb_controller
  import apb_bridge_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADYIN,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [31:0] PRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [2:0]  PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  sel_q, sel_d;
  logic [2:0]  psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;

  logic        dec_mapped;
  logic [2:0]  dec_sel;
  logic        active;
  logic        valid;

  apb_addr_decode u_dec (
    .haddr_i  (HADDR),
    .mapped_o (dec_mapped),
    .psel_o   (dec_sel)
  );

  assign active = HREADYIN && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign valid  = active && dec_mapped;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    psel_d    = psel_q;
    penable_d = 1'b0;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      ST_READ:  state_d = ST_RENABLE;
      ST_WWAIT: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_WENABLE;
`ifdef APB_BRIDGE_ERR_EN
      ST_ERR1:  state_d = ST_ERR2;
`endif
      // IDLE, both ENABLE states and ERR2 all take a new address phase
      default: begin
        if (valid) begin
          state_d = HWRITE ? ST_WWAIT : ST_READ;
          addr_d  = HADDR;
          sel_d   = dec_sel;
`ifdef APB_BRIDGE_ERR_EN
        end else if (active) begin
          state_d = ST_ERR1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    // APB outputs are a function of the state being entered
    case (state_d)
      ST_READ: begin
        psel_d   = sel_d;
        pwrite_d = 1'b0;
        paddr_d  = addr_d;
      end
      ST_WRITE: begin
        psel_d   = sel_d;
        pwrite_d = 1'b1;
        paddr_d  = addr_d;
        pwdata_d = HWDATA;
      end
      ST_RENABLE, ST_WENABLE: penable_d = 1'b1;
      default:                psel_d    = PSEL_NONE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      sel_q     <= PSEL_NONE;
      psel_q    <= PSEL_NONE;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_READ, ST_WWAIT, ST_WRITE: HREADYOUT = 1'b0;
`ifdef APB_BRIDGE_ERR_EN
      ST_ERR1:                     HREADYOUT = 1'b0;
`endif
      default:                     HREADYOUT = 1'b1;
    endcase
  end

`ifdef APB_BRIDGE_ERR_EN
  assign HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign HRESP = HRESP_OKAY;
`endif

  assign HRDATA  = (state_q == ST_RENABLE) ? PRDATA : 32'd0;
  assign PSELx   = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_apb_controller;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADYIN;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] PRDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [2:0]  PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;

  apb_controller dut (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADYIN(HREADYIN), .HADDR(HADDR), .HWDATA(HWDATA), .PRDATA(PRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PSELx(PSELx),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int           cyc;
    logic [103:0] v;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic exp(input int off, input string nm, input logic [2:0] ps, input logic pe,
                     input logic pw, input logic rdy, input logic [1:0] rsp,
                     input logic [31:0] hr, input logic [31:0] pa, input logic [31:0] pd);
    exp_t e;
    e.cyc = cyc + off;
    e.v   = {ps, pe, pw, rdy, rsp, hr, pa, pd};
    q.push_back(e);
    nq.push_back(nm);
  endtask

  always @(negedge HCLK) begin
    logic [103:0] act;
    act = {PSELx, PENABLE, PWRITE, HREADYOUT, HRESP, HRDATA, PADDR, PWDATA};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL %s: not checked at cycle %0d", nq[0], q[0].cyc);
      void'(q.pop_front());
      void'(nq.pop_front());
    end
    while (q.size() > 0 && q[0].cyc == cyc) begin
      total++;
      if (act !== q[0].v) begin
        bad++;
        $display("FAIL %s cyc=%0d got psel/pen/pwr/rdy/resp=%b/%b/%b/%b/%b hrdata=%h paddr=%h pwdata=%h exp=%h",
                 nq[0], cyc, PSELx, PENABLE, PWRITE, HREADYOUT, HRESP, HRDATA, PADDR, PWDATA, q[0].v);
      end
      void'(q.pop_front());
      void'(nq.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ua [2];
    ua[0] = 32'h9000_0000;
    ua[1] = 32'h8C00_0000;

    HRESET = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0; HREADYIN = 1'b1;
    HADDR = 32'h0; HWDATA = 32'h0; PRDATA = 32'h0;
    tick(); tick();
    HRESET = 1'b0;
    exp(0, "reset", 3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0);

    // single read
    HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8400_0010; PRDATA = 32'h0000_002A;
    exp(1, "rd_setup",  3'b010, 0, 0, 0, 2'b00, 32'h0,  32'h8400_0010, 32'h0);
    exp(2, "rd_access", 3'b010, 1, 0, 1, 2'b00, 32'h2A, 32'h8400_0010, 32'h0);
    tick(); idle_bus(); tick();
    exp(1, "rd_idle",   3'b000, 0, 0, 1, 2'b00, 32'h0,  32'h8400_0010, 32'h0);
    tick();

    // single write
    HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8000_0004;
    exp(1, "wr_wwait",  3'b000, 0, 0, 0, 2'b00, 32'h0, 32'h8400_0010, 32'h0);
    exp(2, "wr_setup",  3'b001, 0, 1, 0, 2'b00, 32'h0, 32'h8000_0004, 32'hDEAD_BEEF);
    exp(3, "wr_access", 3'b001, 1, 1, 1, 2'b00, 32'h0, 32'h8000_0004, 32'hDEAD_BEEF);
    exp(4, "wr_idle",   3'b000, 0, 1, 1, 2'b00, 32'h0, 32'h8000_0004, 32'hDEAD_BEEF);
    tick(); idle_bus(); HWDATA = 32'hDEAD_BEEF; tick(); tick(); tick();

    // write then back-to-back read accepted in WENABLE
    HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8800_0000; PRDATA = 32'h0000_0055;
    exp(1, "b2b_wwait",  3'b000, 0, 1, 0, 2'b00, 32'h0, 32'h8000_0004, 32'hDEAD_BEEF);
    exp(2, "b2b_wsetup", 3'b100, 0, 1, 0, 2'b00, 32'h0, 32'h8800_0000, 32'h1234_5678);
    exp(3, "b2b_wacc",   3'b100, 1, 1, 1, 2'b00, 32'h0, 32'h8800_0000, 32'h1234_5678);
    tick(); idle_bus(); HWDATA = 32'h1234_5678; tick(); tick();
    HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8000_0008;
    exp(1, "b2b_rsetup", 3'b001, 0, 0, 0, 2'b00, 32'h0,  32'h8000_0008, 32'h1234_5678);
    exp(2, "b2b_racc",   3'b001, 1, 0, 1, 2'b00, 32'h55, 32'h8000_0008, 32'h1234_5678);
    tick(); idle_bus(); tick();
    exp(1, "b2b_idle",   3'b000, 0, 0, 1, 2'b00, 32'h0,  32'h8000_0008, 32'h1234_5678);
    tick();

    // non-transfers: BUSY, IDLE, HREADYIN low
    HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h8000_0000;
    exp(1, "busy",    3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8000_0008, 32'h1234_5678);
    tick();
    HTRANS = 2'b00;
    exp(1, "idle_tr", 3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8000_0008, 32'h1234_5678);
    tick();
    HTRANS = 2'b10; HREADYIN = 1'b0;
    exp(1, "no_rdyin", 3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8000_0008, 32'h1234_5678);
    tick();
    HREADYIN = 1'b1; idle_bus();

    // top of the last peripheral window
    HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8BFF_FFFC; PRDATA = 32'h0000_0077;
    exp(1, "hi_setup", 3'b100, 0, 0, 0, 2'b00, 32'h0,  32'h8BFF_FFFC, 32'h1234_5678);
    exp(2, "hi_acc",   3'b100, 1, 0, 1, 2'b00, 32'h77, 32'h8BFF_FFFC, 32'h1234_5678);
    tick(); idle_bus(); tick(); tick();

    // unmapped NONSEQ accesses
    for (int i = 0; i < 2; i++) begin
      HTRANS = 2'b10; HWRITE = 1'b0; HADDR = ua[i];
`ifdef APB_BRIDGE_ERR_EN
      exp(1, "err1",     3'b000, 0, 0, 0, 2'b01, 32'h0, 32'h8BFF_FFFC, 32'h1234_5678);
      exp(2, "err2",     3'b000, 0, 0, 1, 2'b01, 32'h0, 32'h8BFF_FFFC, 32'h1234_5678);
      exp(3, "err_done", 3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8BFF_FFFC, 32'h1234_5678);
`else
      exp(1, "unmap1",   3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8BFF_FFFC, 32'h1234_5678);
      exp(2, "unmap2",   3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h8BFF_FFFC, 32'h1234_5678);
`endif
      tick(); idle_bus(); tick(); tick();
    end

    // reset asserted while in ST_WRITE drops the transfer
    HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8400_0020;
    exp(2, "rst_wsetup", 3'b010, 0, 1, 0, 2'b00, 32'h0, 32'h8400_0020, 32'hA5A5_A5A5);
    exp(3, "rst_clear",  3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0);
    exp(4, "rst_idle",   3'b000, 0, 0, 1, 2'b00, 32'h0, 32'h0, 32'h0);
    tick(); idle_bus(); HWDATA = 32'hA5A5_A5A5; tick();
    HRESET = 1'b1; tick();
    HRESET = 1'b0; tick();

    tick(); tick(); tick();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected entries never checked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
